// File: rtl/cdc_hs_tx_fifo_if.sv
// Producer-side ready/valid bus and synchronizer-side head/busy bus of the CDC TX buffer.
// Handshake: a word moves on s_* when s_valid & s_ready at the i_clk edge; hs_data is captured
// when hs_valid & ~hs_busy, and hs_busy then stays high until the far side acknowledges.
interface cdc_hs_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              hs_valid;
  logic [DATA_W-1:0] hs_data;
  logic              hs_busy;

  // Environment side: producer plus synchronizer.
  modport master (
    output s_valid, s_data, hs_busy,
    input  s_ready, hs_valid, hs_data
  );

  // Buffer side.
  modport slave (
    input  s_valid, s_data, hs_busy,
    output s_ready, hs_valid, hs_data
  );
endinterface

// File: rtl/cdc_hs_tx_fifo.sv
// Source-domain elastic buffer feeding a 2-phase handshake synchronizer, one word per round trip.
// Show-ahead head word; flush discards everything except a pop completing in the same cycle.
module cdc_hs_tx_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_flush,
  cdc_hs_tx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     empty,
  output logic [15:0]              sent_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              push;
  logic              pop;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level       = wr_ptr - rd_ptr;
  assign almost_full = (level >= AFULL_LVL);

  // s_ready looks only at registered state, so a same-cycle pop never frees a slot for a push.
  assign bus.s_ready  = ~full & ~i_flush;
  assign bus.hs_valid = ~empty;
  assign bus.hs_data  = mem[rd_ptr[AW-1:0]];

  assign push = bus.s_valid & bus.s_ready;
  assign pop  = bus.hs_valid & ~bus.hs_busy;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.s_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sent_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + {{AW{1'b0}}, push};
      sent_cnt <= sent_cnt + 16'(pop);
      // push is blocked during flush, so wr_ptr is already the post-flush write position.
      if (i_flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
      end
    end
  end
endmodule

// File: tb/tb_cdc_hs_tx_fifo.sv
// Self-checking bench for cdc_hs_tx_fifo: reset, table-driven vectors, full/burst corner cases,
// and random bursty traffic against a queue model with an emulated synchronizer round trip.
module tb_cdc_hs_tx_fifo;
  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int ATH = 6;

  logic        i_clk;
  logic        i_rstn;
  logic        i_flush;
  logic [3:0]  level;
  logic        almost_full;
  logic        empty;
  logic [15:0] sent_cnt;

  logic man_busy;
  logic emu_busy;
  logic emu_en;
  logic mon_en;

  int checks;
  int errors;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] m_q[$];
  int            m_sent;

  cdc_hs_tx_fifo_if #(.DATA_W(DW)) bus ();

  assign bus.hs_busy = emu_en ? emu_busy : man_busy;

  cdc_hs_tx_fifo #(.DATA_W(DW), .DEPTH(DEP), .AFULL_TH(ATH)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_flush     (i_flush),
    .bus         (bus),
    .level       (level),
    .almost_full (almost_full),
    .empty       (empty),
    .sent_cnt    (sent_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    man_busy    = 1'b0;
    i_flush     = 1'b0;
    @(posedge i_clk); #2;
    i_rstn = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_hs_valid", int'(bus.hs_valid), 0);
    chk("rst_s_ready", int'(bus.s_ready), 1);
    chk("rst_sent_cnt", int'(sent_cnt), 0);
    chk("rst_afull", int'(almost_full), 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn      = 1'b1;
    bus.s_valid = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [DW-1:0] d, input int budget);
    bit acc;
    acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge i_clk);
      if (bus.s_ready) acc = 1'b1;
      @(posedge i_clk); #1;
    end
    bus.s_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge i_clk); #1;
      c++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic compare_rx(input string nm);
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      chk(nm, int'(rx_q.pop_front()), int'(exp_q.pop_front()));
    end
    chk({nm, "_leftover"}, exp_q.size() + rx_q.size(), 0);
  endtask

  // ---------------- synchronizer emulation ----------------
  // Captures hs_data on a pop, raises busy the next cycle and holds it for a random round trip.
  initial begin
    bit            p;
    logic [DW-1:0] d;
    int            cnt;
    emu_busy = 1'b0;
    cnt      = 0;
    forever begin
      @(negedge i_clk);
      p = emu_en && bus.hs_valid && !bus.hs_busy;
      d = bus.hs_data;
      @(posedge i_clk); #1;
      if (p) begin
        rx_q.push_back(d);
        emu_busy = 1'b1;
        cnt = $urandom_range(1, 5);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) emu_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model / scoreboard feed ----------------
  // Queue-level model: pop when something is buffered and busy is low, push when room and no flush.
  always @(negedge i_clk) begin
    if (mon_en) begin
      bit do_pop;
      bit do_push;
      do_pop  = (m_q.size() > 0) && !bus.hs_busy;
      do_push = bus.s_valid && (m_q.size() < DEP) && !i_flush;
      chk("m_s_ready", int'(bus.s_ready), int'((m_q.size() < DEP) && !i_flush));
      chk("m_hs_valid", int'(bus.hs_valid), int'(m_q.size() > 0));
      chk("m_level", int'(level), m_q.size());
      chk("m_empty", int'(empty), int'(m_q.size() == 0));
      chk("m_afull", int'(almost_full), int'(m_q.size() >= ATH));
      chk("m_sent_cnt", int'(sent_cnt), m_sent % 65536);
      if (m_q.size() > 0) chk("m_hs_data", int'(bus.hs_data), int'(m_q[0]));
      if (do_pop) begin
        void'(m_q.pop_front());
        m_sent++;
      end
      if (i_flush) m_q.delete();
      if (do_push) begin
        m_q.push_back(bus.s_data);
        exp_q.push_back(bus.s_data);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          sv;
    logic [DW-1:0] d;
    logic          busy;
    logic          fl;
    int            lvl;
    logic          hv;
    logic [DW-1:0] hd;
    int            sent;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // inputs applied for one cycle, then state expected right after that edge
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1};
    tbl[2]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b1, 8'h11, 1};
    tbl[3]  = '{1'b1, 8'h22, 1'b1, 1'b0, 2, 1'b1, 8'h11, 1};
    tbl[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 3, 1'b1, 8'h11, 1};
    tbl[5]  = '{1'b1, 8'h44, 1'b0, 1'b0, 3, 1'b1, 8'h22, 2};
    tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b0, 4, 1'b1, 8'h22, 2};
    tbl[7]  = '{1'b1, 8'h66, 1'b1, 1'b0, 5, 1'b1, 8'h22, 2};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 3};
    tbl[9]  = '{1'b1, 8'h77, 1'b0, 1'b1, 0, 1'b0, 8'h00, 3};
    tbl[10] = '{1'b1, 8'h88, 1'b0, 1'b0, 1, 1'b1, 8'h88, 3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 4};
    tbl[12] = '{1'b1, 8'h99, 1'b1, 1'b0, 1, 1'b1, 8'h99, 4};
    tbl[13] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1, 1'b1, 8'hAA, 5};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 6};

    checks = 0;
    errors = 0;
    i_rstn = 1'b0;
    i_flush = 1'b0;
    man_busy = 1'b0;
    emu_en = 1'b0;
    mon_en = 1'b0;
    m_sent = 0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;

    // reset with producer active
    do_reset();

    // table-driven vectors: single word, push+pop, flush, pop-from-1 with push
    for (int i = 0; i < 15; i++) begin
      bus.s_valid = tbl[i].sv;
      bus.s_data  = tbl[i].d;
      man_busy    = tbl[i].busy;
      i_flush     = tbl[i].fl;
      @(posedge i_clk); #1;
      chk($sformatf("v%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("v%0d_hs_valid", i), int'(bus.hs_valid), int'(tbl[i].hv));
      chk($sformatf("v%0d_empty", i), int'(empty), int'(tbl[i].lvl == 0));
      chk($sformatf("v%0d_afull", i), int'(almost_full), int'(tbl[i].lvl >= ATH));
      chk($sformatf("v%0d_sent", i), int'(sent_cnt), tbl[i].sent);
      if (tbl[i].hv) chk($sformatf("v%0d_hs_data", i), int'(bus.hs_data), int'(tbl[i].hd));
    end
    bus.s_valid = 1'b0;
    i_flush     = 1'b0;

    // fill to full with busy held, 9th word waits
    man_busy = 1'b1;
    for (int k = 1; k <= DEP; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(k);
      @(negedge i_clk);
      chk($sformatf("fill%0d_ready_pre", k), int'(bus.s_ready), 1);
      @(posedge i_clk); #1;
      chk($sformatf("fill%0d_level", k), int'(level), k);
      chk($sformatf("fill%0d_afull", k), int'(almost_full), int'(k >= ATH));
      chk($sformatf("fill%0d_ready", k), int'(bus.s_ready), int'(k < DEP));
    end
    bus.s_data = 8'h09;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("full_ready", int'(bus.s_ready), 0);
      chk("full_level", int'(level), DEP);
    end
    chk("full_head", int'(bus.hs_data), 1);
    // single pop while full and s_valid high: no same-cycle refill
    man_busy = 1'b0;
    @(negedge i_clk);
    chk("full_pop_ready", int'(bus.s_ready), 0);
    @(posedge i_clk); #1;
    man_busy = 1'b1;
    chk("no_bypass_level", int'(level), DEP - 1);
    chk("full_pop_sent", int'(sent_cnt), 7);
    chk("full_next_head", int'(bus.hs_data), 2);
    for (int k = 2; k <= 9; k++) exp_q.push_back(DW'(k));
    rx_q.delete();
    emu_en = 1'b1;
    send_word(8'h09, 200);
    wait_rx(8, 500);
    compare_rx("burst_order");
    chk("burst_sent", int'(sent_cnt), 15);
    repeat (10) @(posedge i_clk);
    #1;
    emu_en = 1'b0;

    // reset while holding data
    man_busy = 1'b1;
    for (int k = 0; k < 3; k++) send_word(8'hC0 + DW'(k), 20);
    chk("pre_rst_level", int'(level), 3);
    do_reset();

    // random bursty traffic against the queue model
    exp_q.delete();
    rx_q.delete();
    m_q.delete();
    m_sent = 0;
    mon_en = 1'b1;
    emu_en = 1'b1;
    for (int n = 0; n < 64; n++) begin
      send_word(DW'($urandom_range(0, 255)), 400);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(posedge i_clk);
      #0;
    end
    wait_rx(64, 3000);
    @(negedge i_clk);
    @(posedge i_clk); #1;
    mon_en = 1'b0;
    chk("rand_sent", int'(sent_cnt), 64);
    compare_rx("rand_order");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
